costas_loop_ctrl: RTL
=====================

Name: costas_loop_ctrl

Overview:
Parametrised successor to the fixed Costas loop filter: a proportional-integral (PI) loop filter with gain scheduling, decimated updates, integrator saturation and lock detection.
- Consumes the signed phase-error stream from the phase detector.
- Produces the frequency/phase-increment word for the DDS config channel.
- Drives status to the demodulator control logic.

Parameters:
W, 35, width of error input, integrator and frequency word
INIT_FREQ, 3453153706, frequency word after reset or force_acq (5 kHz)
DEC, 8, accepted samples per loop update (1 = every sample)
KP_ACQ, 5, proportional right-shift in ACQ
KI_ACQ, 12, integral right-shift in ACQ
KP_TRK, 10, proportional right-shift in TRK/LOCK
KI_TRK, 17, integral right-shift in TRK/LOCK
ACQ_UPDATES, 30000, number of updates spent in ACQ
INT_LIM, 2^(W-3)-1, integrator saturation magnitude
LOCK_TH, 2^16, |err| below this counts as in-lock
LOCK_CNT, 64, consecutive in-lock updates to declare lock; also consecutive out-of-lock updates to drop lock

Ports:
clk, in, 1, loop clock
rstn, in, 1, reset; synchronous, active-low
in_valid, in, 1, in_err qualifier
in_err, in, W, signed phase error
force_acq, in, 1, synchronous restart of acquisition
freq_word, out, W, DDS frequency word (unsigned, modulo 2^W)
freq_valid, out, 1, one-cycle pulse when freq_word updates
state, out, 2, 0=ACQ, 1=TRK, 2=LOCK
locked, out, 1, high iff state==LOCK

Behaviour:
- Reset (rstn=0 at posedge clk) sets:
  - freq_word=INIT_FREQ, freq_valid=0, state=ACQ, locked=0.
  - Integrator, decimation counter, update counter, lock counter and miss counter all 0.
- Priority: rstn > force_acq > sample processing.
- force_acq=1 does the same as reset, except the register-level effect is identical while rstn stays high. A coincident in_valid sample is discarded.
- Decimation:
  - dcnt counts accepted samples (in_valid=1) from 0 to DEC-1.
  - The sample arriving with dcnt==DEC-1 triggers an update; dcnt then wraps to 0.
  - Other samples are ignored for arithmetic.
  - in_valid=0 holds dcnt.
- Update arithmetic (gains kp/ki chosen by state before the update):
  - integ_n = sat(integ + (in_err >>> ki)), where sat clamps to [-INT_LIM, +INT_LIM].
  - freq_word <= INIT_FREQ + integ_n + (in_err >>> kp). Computed at full width, truncated to W bits (wraps).
  - All shifts are arithmetic (sign-extending).
  - The new integrator value is used, not the old one.
- Latency: freq_word and freq_valid change on the clock edge after the triggering sample. freq_valid is high for exactly that one cycle. freq_word holds otherwise.
- |in_err|: magnitude; for the most negative value, saturates to 2^(W-1)-1.
- FSM (evaluated on updates only):
  - ACQ: count updates; on the ACQ_UPDATES-th update go to TRK. This update still uses ACQ gains.
  - TRK: if |err|<LOCK_TH, lock_cnt++ (saturating), else lock_cnt=0. When lock_cnt reaches LOCK_CNT, go to LOCK and clear miss_cnt.
  - LOCK: if |err|>=LOCK_TH, miss_cnt++, else miss_cnt=0. When miss_cnt reaches LOCK_CNT, go to TRK and clear lock_cnt.
  - A state transition becomes visible on the same edge as the freq_word update that caused it.
  - Lock counting is not performed in ACQ.
- state encoding 3 is unreachable; if entered, go to ACQ on the next clock.

Test Plan:
- Reset: hold rstn=0 for 3 clocks with in_valid toggling -> freq_word=3453153706, freq_valid=0, state=0, locked=0 throughout.
- ACQ step (DEC=1), in_err=2^20 for two valid cycles:
  - first update -> freq_word=3453186730;
  - second update -> 3453186986;
  - one freq_valid pulse per update.
  - Then in_err=-2^20 from reset -> 3453120682.
- Decimation (DEC=8): 16 valid samples interleaved with in_valid=0 gaps -> exactly 2 freq_valid pulses, on the 8th and 16th samples. Samples 1-7 do not affect the integrator.
- Gain switch (ACQ_UPDATES=4): on the 4th update state goes to 1. With in_err=2^20 afterwards, per-update integrator increment is 8 and the proportional term is 1024.
- Lock/unlock (LOCK_CNT=4, TRK):
  - 4 updates with in_err=100 -> state=2, locked=1.
  - 3 updates with in_err=2^18 -> stays locked; 4th -> state=1.
  - A single in-lock update in between restarts the miss count.
- Saturation/restart:
  - Sustained in_err=2^(W-1)-1 -> integrator pins at INT_LIM and never wraps.
  - force_acq coincident with in_valid -> freq_word=INIT_FREQ, state=0 next cycle, no freq_valid.

Source files
------------

// File: rtl/costas_loop_ctrl.sv
// Costas loop PI filter: decimated updates, ACQ/TRK gain scheduling,
// saturating integrator and hysteretic lock detection feeding a DDS word.
module costas_loop_ctrl #(
  parameter int W = 35,
  parameter logic [W-1:0] INIT_FREQ = W'(64'd3453153706),
  parameter int DEC = 8,
  parameter int KP_ACQ = 5,
  parameter int KI_ACQ = 12,
  parameter int KP_TRK = 10,
  parameter int KI_TRK = 17,
  parameter int ACQ_UPDATES = 30000,
  parameter logic [W-1:0] INT_LIM = W'((64'd1 << (W - 3)) - 64'd1),
  parameter logic [W-1:0] LOCK_TH = W'(64'd1 << 16),
  parameter int LOCK_CNT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_err,
  input  logic         force_acq,
  output logic [W-1:0] freq_word,
  output logic         freq_valid,
  output logic [1:0]   state,
  output logic         locked
);

  // Handshake: in_err is consumed on every clock where in_valid=1 (no
  // backpressure); freq_valid pulses for one cycle with each new freq_word.

  typedef enum logic [1:0] {
    S_ACQ  = 2'd0,
    S_TRK  = 2'd1,
    S_LOCK = 2'd2,
    S_RSV  = 2'd3
  } state_t;

  localparam int DCW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int UCW = $clog2(ACQ_UPDATES + 1);
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int XW  = W + 2;
  localparam logic [DCW-1:0] DEC_LAST = DCW'(DEC - 1);
  localparam logic [UCW-1:0] UPD_LAST = UCW'(ACQ_UPDATES);
  localparam logic [LCW-1:0] LCNT_MAX = LCW'(LOCK_CNT);
  localparam logic [W-1:0]   MAG_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_t               state_q, state_d;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic [UCW-1:0]       upd_q, upd_d;
  logic [LCW-1:0]       lock_q, lock_d, miss_q, miss_d;
  logic [LCW-1:0]       lock_inc, miss_inc;
  logic signed [W-1:0]  integ_q, integ_n;
  logic signed [W-1:0]  err_s, p_term, i_term;
  logic signed [XW-1:0] sum_x, lim_x, nlim_x;
  logic [W-1:0]         mag, freq_n;
  logic                 do_update, in_lock;

  assign err_s     = $signed(in_err);
  assign do_update = in_valid && (dcnt_q == DEC_LAST);

  always_comb begin
    dcnt_d = dcnt_q;
    if (in_valid) dcnt_d = do_update ? '0 : dcnt_q + DCW'(1);
  end

  // Gains follow the state held before the update, so the last ACQ update
  // still uses ACQ shifts.
  always_comb begin
    p_term = err_s >>> KP_ACQ;
    i_term = err_s >>> KI_ACQ;
    if (state_q != S_ACQ) begin
      p_term = err_s >>> KP_TRK;
      i_term = err_s >>> KI_TRK;
    end
  end

  // Two guard bits keep the pre-clamp sum from wrapping.
  assign lim_x  = {2'b00, INT_LIM};
  assign nlim_x = -lim_x;
  assign sum_x  = {{2{integ_q[W-1]}}, integ_q} + {{2{i_term[W-1]}}, i_term};

  always_comb begin
    integ_n = sum_x[W-1:0];
    if (sum_x > lim_x)       integ_n = lim_x[W-1:0];
    else if (sum_x < nlim_x) integ_n = nlim_x[W-1:0];
  end

  assign freq_n = INIT_FREQ + $unsigned(integ_n) + $unsigned(p_term);

  always_comb begin
    if (!in_err[W-1])          mag = in_err;
    else if (in_err == MOST_NEG) mag = MAG_MAX;
    else                       mag = -in_err;
  end

  assign in_lock  = (mag < LOCK_TH);
  assign lock_inc = (lock_q == LCNT_MAX) ? lock_q : lock_q + LCW'(1);
  assign miss_inc = (miss_q == LCNT_MAX) ? miss_q : miss_q + LCW'(1);

  always_comb begin
    state_d = state_q;
    upd_d   = upd_q;
    lock_d  = lock_q;
    miss_d  = miss_q;
    case (state_q)
      S_ACQ: begin
        if (do_update) begin
          upd_d = upd_q + UCW'(1);
          if (upd_d == UPD_LAST) state_d = S_TRK;
        end
      end
      S_TRK: begin
        if (do_update) begin
          lock_d = in_lock ? lock_inc : '0;
          if (in_lock && (lock_inc == LCNT_MAX)) begin
            state_d = S_LOCK;
            miss_d  = '0;
          end
        end
      end
      S_LOCK: begin
        if (do_update) begin
          miss_d = in_lock ? '0 : miss_inc;
          if (!in_lock && (miss_inc == LCNT_MAX)) begin
            state_d = S_TRK;
            lock_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_ACQ;
        upd_d   = '0;
        lock_d  = '0;
        miss_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || force_acq) begin
      state_q    <= S_ACQ;
      dcnt_q     <= '0;
      upd_q      <= '0;
      lock_q     <= '0;
      miss_q     <= '0;
      integ_q    <= '0;
      freq_word  <= INIT_FREQ;
      freq_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      upd_q      <= upd_d;
      lock_q     <= lock_d;
      miss_q     <= miss_d;
      freq_valid <= do_update;
      if (do_update) begin
        integ_q   <= integ_n;
        freq_word <= freq_n;
      end
    end
  end

  assign state  = state_q;
  assign locked = (state_q == S_LOCK);

endmodule
